// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and width helpers for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int BURST_LEN_DEF = 16;
  localparam int GRANT_W_DEF = $clog2(N_REQ_DEF);
  localparam int CNT_W_DEF = $clog2(BURST_LEN_DEF + 1);
  function automatic int grant_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int cnt_w(input int b);
    return $clog2(b + 1);
  endfunction
endpackage

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick: combinational round-robin picker searching upward from last+1 with wrap
module fifo_arb_rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    win,
  output logic             any
);
  always_comb begin
    win = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(last) + k) % N_REQ]) win = GW'((int'(last) + k) % N_REQ);
    any = |req;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-granular round-robin arbiter for a FIFO write port
// FIFO_ARB_PRIO0_EN: requester 0 wins every arbitration it requests in
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_WIDTH = 10,
  parameter int BURST_LEN = 16
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_full,
  input  logic [DEPTH_WIDTH:0]          fifo_wr_water_level,
  output logic [grant_w(N_REQ)-1:0]     grant_id,
  output logic                          busy
);
  localparam int GW = grant_w(N_REQ);
  localparam int CW = cnt_w(BURST_LEN);
  state_t state;
  logic [GW-1:0] last_grant, win, win_rr;
  logic [CW-1:0] cnt;
  logic [DEPTH_WIDTH:0] free;
  logic [N_REQ-1:0] pick_req;
  logic any_rr, go, done;
`ifdef FIFO_ARB_PRIO0_EN
  assign pick_req = req_valid & ~N_REQ'(1);
  assign win = req_valid[0] ? '0 : win_rr;
`else
  assign pick_req = req_valid;
  assign win = win_rr;
`endif
  fifo_arb_rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .req(pick_req),
    .last(last_grant),
    .win(win_rr),
    .any(any_rr)
  );
  always_comb begin
    free = {1'b1, {DEPTH_WIDTH{1'b0}}} - fifo_wr_water_level;
    busy = state == BURST;
    go = state == IDLE && (any_rr || req_valid[0]) && free >= (DEPTH_WIDTH+1)'(BURST_LEN);
    req_ready = busy && !fifo_wr_full ? N_REQ'(1) << grant_id : '0;
    fifo_wr_en = busy && req_valid[grant_id] && !fifo_wr_full;
    fifo_wr_data = busy ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    done = fifo_wr_en && (req_last[grant_id] || {1'b0, cnt} + 1'b1 == (CW+1)'(BURST_LEN));
  end
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state <= IDLE;
      grant_id <= '0;
      last_grant <= GW'(N_REQ - 1);
      cnt <= '0;
    end else if (go) begin
      state <= BURST;
      grant_id <= win;
      cnt <= '0;
    end else if (done) begin
      state <= IDLE;
      cnt <= cnt + 1'b1;
`ifdef FIFO_ARB_PRIO0_EN
      last_grant <= grant_id == '0 ? last_grant : grant_id;
`else
      last_grant <= grant_id;
`endif
    end else if (fifo_wr_en) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int HN = 200;
  logic clk = 1'b0;
  logic wr_rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic fifo_wr_en, fifo_wr_full = 1'b0, busy;
  logic [DW-1:0] fifo_wr_data;
  logic [10:0] fifo_wr_water_level = '0;
  logic [1:0] grant_id;
  int errs = 0, checks = 0;
  logic rst_v, full_v;
  logic [10:0] lvl;
  logic active [N];
  int rem [N], seq [N], last_idx [N];
  logic busy_h [HN], en_h [HN];
  logic [1:0] gid_h [HN];
  logic [DW-1:0] data_h [HN];
  logic [N-1:0] rdy_h [HN];
  logic [DW-1:0] cap [$];
  int bst [$], bbeat [$];

  fifo_wr_arbiter dut (
    .wr_clk(clk), .wr_rst(wr_rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_wr_water_level(fifo_wr_water_level), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      wr_rst = rst_v;
      fifo_wr_full = full_v;
      fifo_wr_water_level = lvl;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = active[i] && rem[i] != 0;
        req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
        req_last[i] = seq[i] == last_idx[i];
      end
      #1;
      busy_h[k] = busy;
      en_h[k] = fifo_wr_en;
      gid_h[k] = grant_id;
      data_h[k] = fifo_wr_data;
      rdy_h[k] = req_ready;
      if (fifo_wr_en) cap.push_back(fifo_wr_data);
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) begin
          seq[i]++;
          rem[i]--;
        end
    end
  endtask

  task automatic scan(input int n);
    bst.delete();
    bbeat.delete();
    for (int k = 0; k < n; k++) begin
      if (busy_h[k] && (k == 0 || !busy_h[k-1])) begin
        bst.push_back(k);
        bbeat.push_back(0);
      end
      if (en_h[k] && bbeat.size() > 0) bbeat[bbeat.size()-1]++;
    end
  endtask

  task automatic apply_reset();
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0;
      rem[i] = -1;
      seq[i] = 0;
      last_idx[i] = -1;
    end
    lvl = '0;
    full_v = 1'b0;
    rst_v = 1'b1;
    run_cycles(2);
    rst_v = 1'b0;
    cap.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    active[0] = 1'b1;
    rst_v = 1'b1;
    run_cycles(3);
    rst_v = 1'b0;
    checks += 5;
    if (busy_h[2] !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy_h[2]); end
    if (rdy_h[2] !== 4'b0) begin errs++; $display("FAIL reset_ready got %b want 0000", rdy_h[2]); end
    if (en_h[2] !== 1'b0) begin errs++; $display("FAIL reset_wr_en got %b want 0", en_h[2]); end
    if (data_h[2] !== 32'h0) begin errs++; $display("FAIL reset_wr_data got %h want 0", data_h[2]); end
    if (gid_h[2] !== 2'd0) begin errs++; $display("FAIL reset_grant_id got %0d want 0", gid_h[2]); end
  endtask

  task automatic test_basic_burst();
    int exp_st [3] = '{1, 18, 35};
    int exp_bt [3] = '{16, 16, 8};
    apply_reset();
    active[1] = 1'b1;
    rem[1] = 40;
    run_cycles(60);
    scan(60);
    checks++;
    if (bst.size() != 3) begin errs++; $display("FAIL basic_burst_count got %0d want 3", bst.size()); end
    for (int j = 0; j < 3 && j < bst.size(); j++) begin
      checks += 3;
      if (bst[j] != exp_st[j]) begin errs++; $display("FAIL basic_start%0d got %0d want %0d", j, bst[j], exp_st[j]); end
      if (bbeat[j] != exp_bt[j]) begin errs++; $display("FAIL basic_beats%0d got %0d want %0d", j, bbeat[j], exp_bt[j]); end
      if (gid_h[bst[j]] !== 2'd1) begin errs++; $display("FAIL basic_grant%0d got %0d want 1", j, gid_h[bst[j]]); end
    end
    checks++;
    if (cap.size() != 40) begin errs++; $display("FAIL basic_word_count got %0d want 40", cap.size()); end
    for (int j = 0; j < 40 && j < cap.size(); j++) begin
      checks++;
      if (cap[j] !== {8'd1, 24'(j)}) begin errs++; $display("FAIL basic_word%0d got %h want %h", j, cap[j], {8'd1, 24'(j)}); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int i = 0; i < N; i++) active[i] = 1'b1;
    run_cycles(90);
    scan(90);
    checks++;
    if (bst.size() < 5) begin errs++; $display("FAIL rr_burst_count got %0d want >=5", bst.size()); end
    for (int j = 0; j < 5 && j < bst.size(); j++) begin
      checks += 3;
      if (gid_h[bst[j]] !== exp_g[j]) begin errs++; $display("FAIL rr_grant%0d got %0d want %0d", j, gid_h[bst[j]], exp_g[j]); end
      if (bst[j] != 1 + 17 * j) begin errs++; $display("FAIL rr_start%0d got %0d want %0d", j, bst[j], 1 + 17 * j); end
      if (data_h[bst[j]][31:24] !== 8'(exp_g[j])) begin errs++; $display("FAIL rr_src%0d got %0d want %0d", j, data_h[bst[j]][31:24], exp_g[j]); end
    end
  endtask

  task automatic test_space_gating();
    apply_reset();
    lvl = 11'd1009;
    active[0] = 1'b1;
    run_cycles(5);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (busy_h[k] !== 1'b0 || rdy_h[k] !== 4'b0) begin
        errs++; $display("FAIL space_hold%0d got busy=%b ready=%b want 0/0000", k, busy_h[k], rdy_h[k]);
      end
    end
    lvl = 11'd1008;
    run_cycles(3);
    checks += 3;
    if (busy_h[0] !== 1'b0) begin errs++; $display("FAIL space_pick_edge got %b want 0", busy_h[0]); end
    if (busy_h[1] !== 1'b1) begin errs++; $display("FAIL space_grant got %b want 1", busy_h[1]); end
    if (rdy_h[1] !== 4'b0001) begin errs++; $display("FAIL space_ready got %b want 0001", rdy_h[1]); end
  endtask

  task automatic test_early_end();
    apply_reset();
    active[2] = 1'b1;
    active[3] = 1'b1;
    last_idx[2] = 4;
    run_cycles(12);
    scan(12);
    checks++;
    if (bst.size() < 2) begin errs++; $display("FAIL early_burst_count got %0d want >=2", bst.size()); end
    else begin
      checks += 5;
      if (gid_h[bst[0]] !== 2'd2) begin errs++; $display("FAIL early_first_grant got %0d want 2", gid_h[bst[0]]); end
      if (bbeat[0] != 5) begin errs++; $display("FAIL early_beats got %0d want 5", bbeat[0]); end
      if (bst[1] != 7) begin errs++; $display("FAIL early_next_start got %0d want 7", bst[1]); end
      if (gid_h[bst[1]] !== 2'd3) begin errs++; $display("FAIL early_next_grant got %0d want 3", gid_h[bst[1]]); end
      if (data_h[5] !== {8'd2, 24'd4}) begin errs++; $display("FAIL early_last_word got %h want %h", data_h[5], {8'd2, 24'd4}); end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    active[0] = 1'b1;
    active[1] = 1'b1;
    run_cycles(24);
    rst_v = 1'b1;
    run_cycles(1);
    checks += 2;
    if (en_h[0] !== 1'b1) begin errs++; $display("FAIL midrst_beat7_en got %b want 1", en_h[0]); end
    if (gid_h[0] !== 2'd1) begin errs++; $display("FAIL midrst_beat7_grant got %0d want 1", gid_h[0]); end
    rst_v = 1'b0;
    run_cycles(4);
    checks += 6;
    if (busy_h[0] !== 1'b0) begin errs++; $display("FAIL midrst_busy got %b want 0", busy_h[0]); end
    if (en_h[0] !== 1'b0) begin errs++; $display("FAIL midrst_wr_en got %b want 0", en_h[0]); end
    if (rdy_h[0] !== 4'b0) begin errs++; $display("FAIL midrst_ready got %b want 0000", rdy_h[0]); end
    if (data_h[0] !== 32'h0) begin errs++; $display("FAIL midrst_data got %h want 0", data_h[0]); end
    if (busy_h[1] !== 1'b1) begin errs++; $display("FAIL midrst_regrant got %b want 1", busy_h[1]); end
    if (gid_h[1] !== 2'd0) begin errs++; $display("FAIL midrst_first_grant got %0d want 0", gid_h[1]); end
  endtask

  task automatic test_prio0();
`ifdef FIFO_ARB_PRIO0_EN
    logic [1:0] exp_g [3] = '{2'd0, 2'd0, 2'd0};
`else
    logic [1:0] exp_g [3] = '{2'd0, 2'd3, 2'd0};
`endif
    apply_reset();
    active[0] = 1'b1;
    active[3] = 1'b1;
    run_cycles(55);
    scan(55);
    checks++;
    if (bst.size() < 3) begin errs++; $display("FAIL prio_burst_count got %0d want >=3", bst.size()); end
    for (int j = 0; j < 3 && j < bst.size(); j++) begin
      checks++;
      if (gid_h[bst[j]] !== exp_g[j]) begin errs++; $display("FAIL prio_grant%0d got %0d want %0d", j, gid_h[bst[j]], exp_g[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_space_gating();
    test_early_end();
    test_reset_mid_burst();
    test_prio0();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
